addr_decode_ws: RTL and testbench
=================================

// Module: addr_decode_ws
// PURPOSE
//  Parametrised address decoder with per-region wait-state generation for the 6502 bus.
//  Matches a latched CPU address against NUM_REGIONS base/mask windows and drives one-hot chip selects.
//  Holds CPU rdy low for the selected region's programmed wait count.
//  Sits between the CPU bus interface and the RAM/ROM/IO slaves; supersedes the fixed RAM/ROM split.
// PARAMETERS
//  ADDR_W      16                        address width
//  NUM_REGIONS 2                         number of decode windows (1..16)
//  WAIT_W      4                         wait-count field width per region
//  REGION_BASE {16'h8000,16'h0000}       packed NUM_REGIONS*ADDR_W bases, region 0 at LSBs
//  REGION_MASK {16'h8000,16'h8000}       packed masks; 1 = bit compared
//  REGION_WAIT {4'd2,4'd0}               packed NUM_REGIONS*WAIT_W wait cycles per region
// PORTS
//  clk        in   1            system clock, all logic rising-edge
//  rst        in   1            asynchronous, active-high reset
//  addr       in   ADDR_W       CPU address, valid when cyc_start is high
//  cyc_start  in   1            one-clk pulse: new bus cycle begins
//  cyc_end    in   1            one-clk pulse: current bus cycle ends
//  cs         out  NUM_REGIONS  one-hot registered chip selects
//  rdy        out  1            CPU ready; low = stretch cycle
//  unmapped   out  1            one-clk pulse: started address hit no region
//  overrun    out  1            one-clk pulse: cyc_start seen while in WAIT
//  busy       out  1            high whenever state != IDLE
// BEHAVIOUR
//  Reset (async): state=IDLE, cs=0, rdy=1, unmapped=0, overrun=0, busy=0, wait counter=0, latched index=0.
//  Match rule: region i hits iff (addr & MASK[i]) == (BASE[i] & MASK[i]).
//    Lowest index wins on overlap; cs is never multi-hot.
//  States: IDLE, WAIT, HOLD. Cycle N = clk edge where cyc_start is sampled.
//  IDLE + cyc_start:
//    - Hit region k with W=WAIT[k]: at N+1 cs[k]=1.
//    - W=0: rdy stays 1, go HOLD.
//    - W>0: rdy=0 from N+1 through N+W, counter loads W-1, go WAIT.
//    - No hit: cs stays 0, unmapped=1 at N+1 only, rdy stays 1, stays IDLE.
//  WAIT: counter decrements each clk.
//    - At 0 on the next edge: rdy=1, go HOLD (rdy high at N+W+1).
//    - cyc_end in WAIT aborts: next cycle cs=0, rdy=1, IDLE.
//    - cyc_start in WAIT is ignored; overrun=1 for one clk.
//  HOLD: cs held, rdy=1.
//    - cyc_end alone: cs=0 next cycle, go IDLE.
//    - cyc_end and cyc_start together: end current and decode new address in the same edge.
//      cs switches directly to the new one-hot with no idle gap; wait rules as from IDLE.
//    - cyc_start without cyc_end: treated as end+start, same as the simultaneous case.
//  IDLE + cyc_end with no cyc_start: ignored.
//  Wait-count width: WAIT_W bits, max 2^WAIT_W-1 cycles; no wrap, counter saturates at 0.
//  Reset mid-WAIT or mid-HOLD: outputs return to reset values immediately (async).
//  Latency: decode to cs is exactly 1 clk; rdy deassertion coincides with cs assertion.
// TESTING
//  1. Defaults: addr=0x1234 start, end 3 clks later -> cs=01 at N+1, rdy stays 1, cs=00 after end.
//  2. Defaults: addr=0x8000 start -> cs=10 at N+1; rdy=0 at N+1,N+2; rdy=1 at N+3.
//  3. Sweep all 2^16 addresses with defaults -> <0x8000 selects cs[0], >=0x8000 selects cs[1], never both.
//  4. NUM_REGIONS=3, region2 base 0xC000 mask 0xF000, region1 base 0x8000 mask 0x8000:
//     - addr=0xC010 -> cs[1] (priority); addr=0x0000 with region0 mask 0xC000 base 0x4000 -> unmapped pulse.
//  5. HOLD on region0 + simultaneous cyc_end/cyc_start to 0x9000 -> cs 01->10 in one edge, rdy low 2 clks.
//  6. cyc_start during WAIT -> overrun pulse, cs unchanged.
//     rst asserted mid-WAIT -> cs=0, rdy=1 immediately.

Source files
------------

// File: rtl/addr_decode_ws_if.sv
// Bus-side signal bundle for addr_decode_ws: the CPU cycle strobes in, and
// the chip selects, ready and status pulses back out.
interface addr_decode_ws_if #(
  parameter int ADDR_W      = 16,
  parameter int NUM_REGIONS = 2
);
  logic [ADDR_W-1:0]      addr;
  logic                   cyc_start;
  logic                   cyc_end;
  logic [NUM_REGIONS-1:0] cs;
  logic                   rdy;
  logic                   unmapped;
  logic                   overrun;
  logic                   busy;

  modport master (
    output addr, cyc_start, cyc_end,
    input  cs, rdy, unmapped, overrun, busy
  );

  modport slave (
    input  addr, cyc_start, cyc_end,
    output cs, rdy, unmapped, overrun, busy
  );
endinterface

// File: rtl/addr_decode_ws.sv
// 6502 address decoder: matches the started address against base/mask windows,
// drives registered one-hot chip selects and stretches rdy by the region's wait count.
module addr_decode_ws #(
  parameter int                            ADDR_W      = 16,
  parameter int                            NUM_REGIONS = 2,
  parameter int                            WAIT_W      = 4,
  parameter logic [NUM_REGIONS*ADDR_W-1:0] REGION_BASE = {16'h8000, 16'h0000},
  parameter logic [NUM_REGIONS*ADDR_W-1:0] REGION_MASK = {16'h8000, 16'h8000},
  parameter logic [NUM_REGIONS*WAIT_W-1:0] REGION_WAIT = {4'd2, 4'd0}
) (
  input  logic              clk,
  input  logic              rst,
  addr_decode_ws_if.slave   bus
);

  localparam int IDX_W = (NUM_REGIONS > 1) ? $clog2(NUM_REGIONS) : 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  state_t                 state_r, state_s;
  logic [NUM_REGIONS-1:0] cs_r, cs_s, match_s;
  logic                   rdy_r, rdy_s;
  logic                   unmapped_r, unmapped_s;
  logic                   overrun_r, overrun_s;
  logic                   busy_r;
  logic [WAIT_W-1:0]      cnt_r, cnt_s, hit_wait_s;
  logic [IDX_W-1:0]       hit_idx_s;
  logic                   hit_s;
  logic                   start_new_s;

  // Window match; scanning downward lets the lowest matching index win.
  always_comb begin
    match_s    = {NUM_REGIONS{1'b0}};
    hit_idx_s  = {IDX_W{1'b0}};
    hit_wait_s = {WAIT_W{1'b0}};
    for (int i = NUM_REGIONS - 1; i >= 0; i--) begin
      match_s[i] = ((bus.addr & REGION_MASK[i*ADDR_W +: ADDR_W]) ==
                    (REGION_BASE[i*ADDR_W +: ADDR_W] & REGION_MASK[i*ADDR_W +: ADDR_W]));
      hit_idx_s  = match_s[i] ? IDX_W'(i) : hit_idx_s;
      hit_wait_s = match_s[i] ? REGION_WAIT[i*WAIT_W +: WAIT_W] : hit_wait_s;
    end
    hit_s = |match_s;
  end

  // Next-state and next-output logic; a start from HOLD is a combined end+start.
  always_comb begin
    state_s     = state_r;
    cs_s        = cs_r;
    rdy_s       = rdy_r;
    cnt_s       = cnt_r;
    unmapped_s  = 1'b0;
    overrun_s   = 1'b0;
    start_new_s = 1'b0;

    case (state_r)
      ST_IDLE: begin
        start_new_s = bus.cyc_start;
      end
      ST_WAIT: begin
        overrun_s = bus.cyc_start;
        if (bus.cyc_end) begin
          state_s = ST_IDLE;
          cs_s    = {NUM_REGIONS{1'b0}};
          rdy_s   = 1'b1;
          cnt_s   = {WAIT_W{1'b0}};
        end else if (cnt_r == {WAIT_W{1'b0}}) begin
          state_s = ST_HOLD;
          rdy_s   = 1'b1;
        end else begin
          cnt_s = cnt_r - WAIT_W'(1);
        end
      end
      ST_HOLD: begin
        if (bus.cyc_start) begin
          start_new_s = 1'b1;
        end else if (bus.cyc_end) begin
          state_s = ST_IDLE;
          cs_s    = {NUM_REGIONS{1'b0}};
        end else begin
          start_new_s = 1'b0;
        end
      end
      default: begin
        state_s = ST_IDLE;
        cs_s    = {NUM_REGIONS{1'b0}};
        rdy_s   = 1'b1;
        cnt_s   = {WAIT_W{1'b0}};
      end
    endcase

    if (start_new_s) begin
      cs_s = {NUM_REGIONS{1'b0}};
      if (hit_s) begin
        cs_s[hit_idx_s] = 1'b1;
        if (hit_wait_s == {WAIT_W{1'b0}}) begin
          state_s = ST_HOLD;
          rdy_s   = 1'b1;
          cnt_s   = {WAIT_W{1'b0}};
        end else begin
          state_s = ST_WAIT;
          rdy_s   = 1'b0;
          cnt_s   = hit_wait_s - WAIT_W'(1);
        end
      end else begin
        state_s    = ST_IDLE;
        rdy_s      = 1'b1;
        cnt_s      = {WAIT_W{1'b0}};
        unmapped_s = 1'b1;
      end
    end else begin
      unmapped_s = 1'b0;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= ST_IDLE;
      cs_r       <= {NUM_REGIONS{1'b0}};
      rdy_r      <= 1'b1;
      cnt_r      <= {WAIT_W{1'b0}};
      unmapped_r <= 1'b0;
      overrun_r  <= 1'b0;
      busy_r     <= 1'b0;
    end else begin
      state_r    <= state_s;
      cs_r       <= cs_s;
      rdy_r      <= rdy_s;
      cnt_r      <= cnt_s;
      unmapped_r <= unmapped_s;
      overrun_r  <= overrun_s;
      busy_r     <= (state_s != ST_IDLE);
    end
  end

  assign bus.cs       = cs_r;
  assign bus.rdy      = rdy_r;
  assign bus.unmapped = unmapped_r;
  assign bus.overrun  = overrun_r;
  assign bus.busy     = busy_r;

endmodule

// File: tb/tb_addr_decode_ws.sv
// Bench for addr_decode_ws: a transaction-level reference model checked every cycle
// against the default-configured decoder, plus directed literal checks on a 3-region instance.
module tb_addr_decode_ws;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  addr_decode_ws_if #(.ADDR_W(16), .NUM_REGIONS(2)) bus_a ();
  addr_decode_ws_if #(.ADDR_W(16), .NUM_REGIONS(3)) bus_b ();

  addr_decode_ws dut_a (.clk(clk), .rst(rst), .bus(bus_a));

  addr_decode_ws #(
    .ADDR_W(16), .NUM_REGIONS(3), .WAIT_W(4),
    .REGION_BASE({16'hC000, 16'h8000, 16'h4000}),
    .REGION_MASK({16'hF000, 16'h8000, 16'hC000}),
    .REGION_WAIT({4'd3, 4'd1, 4'd0})
  ) dut_b (.clk(clk), .rst(rst), .bus(bus_b));

  assign bus_b.addr      = bus_a.addr;
  assign bus_b.cyc_start = bus_a.cyc_start;
  assign bus_b.cyc_end   = bus_a.cyc_end;

  // Reference model for the default configuration: current region (-1 none)
  // and number of rdy-low cycles still owed.
  int   m_base [2] = '{32'h0000, 32'h8000};
  int   m_mask [2] = '{32'h8000, 32'h8000};
  int   m_wait [2] = '{0, 2};
  int   m_cur   = -1;
  int   m_stall = 0;
  bit   m_unm   = 1'b0;
  bit   m_ovr   = 1'b0;

  function automatic int decode(input int a);
    for (int i = 0; i < 2; i++)
      if ((a & m_mask[i]) == (m_base[i] & m_mask[i])) return i;
    return -1;
  endfunction

  always @(posedge clk or posedge rst) begin : model
    bit s, e;
    int a;
    if (rst) begin
      m_cur = -1; m_stall = 0; m_unm = 1'b0; m_ovr = 1'b0;
    end else begin
      s = bus_a.cyc_start; e = bus_a.cyc_end; a = int'(bus_a.addr);
      m_unm = 1'b0; m_ovr = 1'b0;
      if (m_cur >= 0 && m_stall > 0) begin
        m_ovr = s;
        if (e) begin m_cur = -1; m_stall = 0; end
        else m_stall = m_stall - 1;
      end else if (s) begin
        m_cur = decode(a);
        if (m_cur < 0) begin m_unm = 1'b1; m_stall = 0; end
        else m_stall = m_wait[m_cur];
      end else if (e) begin
        m_cur = -1;
      end
    end
  end

  // Every-cycle comparison of the default instance against the model.
  always @(negedge clk) begin : compare
    logic [5:0] act, exp;
    if (!rst) begin
      exp = {(m_cur < 0) ? 2'b00 : (2'b01 << m_cur), (m_stall == 0), m_unm, m_ovr, (m_cur >= 0)};
      act = {bus_a.cs, bus_a.rdy, bus_a.unmapped, bus_a.overrun, bus_a.busy};
      total++;
      if (act !== exp) begin
        bad++;
        $display("FAIL model t=%0t {cs,rdy,unmapped,overrun,busy}: got %b want %b", $time, act, exp);
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic step(input logic s, input logic e, input logic [15:0] a);
    bus_a.cyc_start = s;
    bus_a.cyc_end   = e;
    bus_a.addr      = a;
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    logic [15:0] a;
    bus_a.cyc_start = 1'b0;
    bus_a.cyc_end   = 1'b0;
    bus_a.addr      = 16'h0000;
    repeat (2) @(negedge clk);
    chk("reset_cs", 32'(bus_a.cs), 32'h0);
    chk("reset_rdy_busy", {30'h0, bus_a.rdy, bus_a.busy}, 32'h2);
    chk("reset_pulses", {30'h0, bus_a.unmapped, bus_a.overrun}, 32'h0);
    rst = 1'b0;

    // Region 0, no wait, ended three clocks later.
    step(1'b1, 1'b0, 16'h1234);
    chk("t1_cs", 32'(bus_a.cs), 32'h1);
    chk("t1_rdy", 32'(bus_a.rdy), 32'h1);
    step(1'b0, 1'b0, 16'h0000);
    step(1'b0, 1'b0, 16'h0000);
    step(1'b0, 1'b1, 16'h0000);
    chk("t1_end_cs", 32'(bus_a.cs), 32'h0);

    // Region 1, two wait states.
    step(1'b1, 1'b0, 16'h8000);
    chk("t2_cs", 32'(bus_a.cs), 32'h2);
    chk("t2_rdy_n1", 32'(bus_a.rdy), 32'h0);
    step(1'b0, 1'b0, 16'h0000);
    chk("t2_rdy_n2", 32'(bus_a.rdy), 32'h0);
    step(1'b0, 1'b0, 16'h0000);
    chk("t2_rdy_n3", 32'(bus_a.rdy), 32'h1);
    step(1'b0, 1'b1, 16'h0000);

    // Back-to-back: HOLD on region 0 then end+start to region 1 in one edge.
    step(1'b1, 1'b0, 16'h0100);
    chk("t5_cs0", 32'(bus_a.cs), 32'h1);
    step(1'b1, 1'b1, 16'h9000);
    chk("t5_cs1", 32'(bus_a.cs), 32'h2);
    chk("t5_rdy_a", 32'(bus_a.rdy), 32'h0);
    step(1'b0, 1'b0, 16'h0000);
    chk("t5_rdy_b", 32'(bus_a.rdy), 32'h0);
    step(1'b0, 1'b0, 16'h0000);
    chk("t5_rdy_c", 32'(bus_a.rdy), 32'h1);
    step(1'b0, 1'b1, 16'h0000);

    // Three-region instance: priority on overlap and an unmapped address.
    step(1'b1, 1'b0, 16'hC010);
    chk("t4_prio_cs", 32'(bus_b.cs), 32'h2);
    step(1'b0, 1'b1, 16'h0000);
    step(1'b1, 1'b0, 16'h4123);
    chk("t4_r0_cs", 32'(bus_b.cs), 32'h1);
    step(1'b0, 1'b1, 16'h0000);
    step(1'b1, 1'b0, 16'h0000);
    chk("t4_unmapped", {28'h0, bus_b.cs, bus_b.unmapped}, 32'h1);
    chk("t4_unm_busy", 32'(bus_b.busy), 32'h0);
    step(1'b0, 1'b0, 16'h0000);
    chk("t4_unm_pulse", 32'(bus_b.unmapped), 32'h0);
    step(1'b0, 1'b1, 16'h0000);

    // Start during WAIT: overrun pulse, selection unchanged.
    step(1'b1, 1'b0, 16'h8000);
    step(1'b1, 1'b0, 16'h0000);
    chk("t6_overrun", 32'(bus_a.overrun), 32'h1);
    chk("t6_cs", 32'(bus_a.cs), 32'h2);
    step(1'b0, 1'b0, 16'h0000);
    chk("t6_ovr_pulse", 32'(bus_a.overrun), 32'h0);
    step(1'b0, 1'b1, 16'h0000);

    // Asynchronous reset in the middle of a wait.
    step(1'b1, 1'b0, 16'hF000);
    bus_a.cyc_start = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("t6_rst_cs", 32'(bus_a.cs), 32'h0);
    chk("t6_rst_rdy", {30'h0, bus_a.rdy, bus_a.busy}, 32'h2);
    @(negedge clk);
    rst = 1'b0;

    // Address sweep (strided, with edge addresses) against the MSB split.
    for (int k = 0; k < 4100; k++) begin
      case (k)
        4096:    a = 16'h7FFF;
        4097:    a = 16'h8000;
        4098:    a = 16'hFFFF;
        4099:    a = 16'h0000;
        default: a = 16'(k * 16 + (k % 16));
      endcase
      step(1'b1, 1'b0, a);
      chk("sweep_cs", 32'(bus_a.cs), (a < 16'h8000) ? 32'h1 : 32'h2);
      step(1'b0, 1'b1, 16'h0000);
    end

    // Random cycles checked by the model.
    for (int k = 0; k < 4000; k++)
      step(($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0), 16'($urandom));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
